// File: rtl/word_chunk_serializer_pkg.sv
// Shared constants and state encoding for the narrow inter-core field link.
// Used by both the chunk serializer and the matching chunk receiver.
package word_chunk_serializer_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned CHUNK_W     = 5;
   localparam int unsigned NUM_CHUNKS  = (WORD_W + CHUNK_W - 1) / CHUNK_W;
   localparam int unsigned CHUNK_IDX_W = 3;

   typedef enum logic {
      StIdle = 1'b0,
      StSend = 1'b1
   } state_e;

endpackage

// File: rtl/word_chunk_serializer.sv
// Serializes a word LSB-first into CHUNK_W-bit chunks on a valid/ready stream,
// optionally trimming trailing all-zero upper chunks.
module word_chunk_serializer
   import word_chunk_serializer_pkg::*;
#(
   parameter bit TRIM_EN = 1'b1
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   InValid,
   output logic                   InReady,
   input  logic [WORD_W-1:0]      InWord,
   output logic                   OutValid,
   input  logic                   OutReady,
   output logic [CHUNK_W-1:0]     OutChunk,
   output logic                   OutLast,
   output logic [CHUNK_IDX_W-1:0] OutIndex,
   output logic                   Busy
);

   state_e                   state_q, state_d;
   logic [WORD_W-1:0]        shreg_q, shreg_d;
   logic [CHUNK_IDX_W-1:0]   idx_q, idx_d;
   logic                     send;
   logic                     is_last;

   assign send = (state_q == StSend);

   // Upper bits of the shift register already hold only what is still unsent.
   assign is_last = (idx_q == CHUNK_IDX_W'(NUM_CHUNKS - 1)) ||
                    (TRIM_EN && (shreg_q[WORD_W-1:CHUNK_W] == '0));

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (InValid) begin
               shreg_d = InWord;
               idx_d   = '0;
               state_d = StSend;
            end
         end
         StSend: begin
            if (OutReady) begin
               if (is_last) begin
                  state_d = StIdle;
               end else begin
                  shreg_d = shreg_q >> CHUNK_W;
                  idx_d   = idx_q + CHUNK_IDX_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
         shreg_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
      end
   end

   assign InReady  = (state_q == StIdle) && !Reset;
   assign OutValid = send;
   assign OutChunk = send ? shreg_q[CHUNK_W-1:0] : '0;
   assign OutLast  = send && is_last;
   assign OutIndex = send ? idx_q : '0;
   assign Busy     = send;

endmodule

// File: tb/tb_word_chunk_serializer.sv
// Directed and randomized checks of the chunk serializer in both trim modes
// against a reference model built from the chunking rules.
module tb_word_chunk_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        sel = 1'b0;
   logic [31:0] in_word = '0;

   int checks = 0;
   int errors = 0;

   logic       iv_t, ir_t, ov_t, ol_t, bz_t;
   logic [4:0] oc_t;
   logic [2:0] oi_t;
   logic       iv_n, ir_n, ov_n, ol_n, bz_n;
   logic [4:0] oc_n;
   logic [2:0] oi_n;
   logic       ir, ov, ol, bz;
   logic [4:0] oc;
   logic [2:0] oi;

   assign iv_t = in_valid && !sel;
   assign iv_n = in_valid && sel;
   assign ir = sel ? ir_n : ir_t;
   assign ov = sel ? ov_n : ov_t;
   assign ol = sel ? ol_n : ol_t;
   assign bz = sel ? bz_n : bz_t;
   assign oc = sel ? oc_n : oc_t;
   assign oi = sel ? oi_n : oi_t;

   word_chunk_serializer #(.TRIM_EN(1'b1)) dut_trim (
      .Clk(clk), .Reset(rst), .InValid(iv_t), .InReady(ir_t), .InWord(in_word),
      .OutValid(ov_t), .OutReady(out_ready), .OutChunk(oc_t), .OutLast(ol_t),
      .OutIndex(oi_t), .Busy(bz_t)
   );

   word_chunk_serializer #(.TRIM_EN(1'b0)) dut_full (
      .Clk(clk), .Reset(rst), .InValid(iv_n), .InReady(ir_n), .InWord(in_word),
      .OutValid(ov_n), .OutReady(out_ready), .OutChunk(oc_n), .OutLast(ol_n),
      .OutIndex(oi_n), .Busy(bz_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Number of chunks the link must carry for word w.
   function automatic int n_chunks(input logic [31:0] w, input bit trim);
      int n;
      if (!trim) return 7;
      n = 1;
      for (int k = 1; k < 7; k++) if ((w >> (5 * k)) != 0) n = k + 1;
      return n;
   endfunction

   function automatic logic [31:0] exp_chunk(input logic [31:0] w, input int k);
      return (w >> (5 * k)) & 32'h1f;
   endfunction

   // Called at a negedge with the selected DUT idle; returns at a negedge in IDLE.
   task automatic send_word(input logic [31:0] w, input bit trim, input int stall_idx,
                            input int stall_len, input bit rnd_stall, input bit hold_valid);
      int          n;
      int          waitc;
      int          stalls;
      bit          r;
      logic [31:0] acc;
      sel = !trim;
      n = n_chunks(w, trim);
      acc = '0;
      waitc = 0;
      #1;
      while (!ir && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      chk("in_ready_idle", {31'b0, ir}, 32'd1);
      in_valid = 1'b1;
      in_word = w;
      @(posedge clk);
      @(negedge clk);
      if (hold_valid) in_word = ~w;
      else in_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         stalls = 0;
         while (1) begin
            if (k == stall_idx && stalls < stall_len) r = 1'b0;
            else if (rnd_stall && stalls < 3) r = 1'($urandom_range(0, 1));
            else r = 1'b1;
            out_ready = r;
            chk("out_valid", {31'b0, ov}, 32'd1);
            chk("out_chunk", {27'b0, oc}, exp_chunk(w, k));
            chk("out_index", {29'b0, oi}, k);
            chk("out_last", {31'b0, ol}, (k == n - 1) ? 32'd1 : 32'd0);
            chk("in_ready_send", {31'b0, ir}, 32'd0);
            chk("busy_send", {31'b0, bz}, 32'd1);
            if (r) break;
            stalls++;
            @(negedge clk);
         end
         acc = acc | ({27'b0, oc} << (5 * k));
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("out_valid_idle", {31'b0, ov}, 32'd0);
      chk("busy_idle", {31'b0, bz}, 32'd0);
      chk("in_ready_after", {31'b0, ir}, 32'd1);
      chk("reassembled", acc, w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'b0, ov_t}, 32'd0);
      chk("rst_in_ready", {31'b0, ir_t}, 32'd0);
      chk("rst_out_last", {31'b0, ol_t}, 32'd0);
      chk("rst_out_chunk", {27'b0, oc_t}, 32'd0);
      chk("rst_out_index", {29'b0, oi_t}, 32'd0);
      chk("rst_busy", {31'b0, bz_t}, 32'd0);
      rst = 1'b0;
      #1;
      chk("in_ready_post_rst", {31'b0, ir_t}, 32'd1);
      chk("in_ready_post_rst_full", {31'b0, ir_n}, 32'd1);

      send_word(32'h0000_0013, 1'b1, -1, 0, 1'b0, 1'b0);
      send_word(32'hFFFF_FFFF, 1'b1, -1, 0, 1'b0, 1'b0);
      send_word(32'h0000_0020, 1'b1, -1, 0, 1'b0, 1'b0);
      send_word(32'h1234_5678, 1'b1, 2, 3, 1'b0, 1'b0);
      send_word(32'h0000_0013, 1'b0, -1, 0, 1'b0, 1'b0);
      send_word(32'h8000_0000, 1'b1, -1, 0, 1'b0, 1'b1);
      send_word(32'h1234_5678, 1'b0, 6, 2, 1'b0, 1'b1);

      // Reset pulsed while index 3 of an all-ones word is on the bus.
      sel = 1'b0;
      in_valid = 1'b1;
      in_word = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("pre_rst_chunk", {27'b0, oc}, 32'h1f);
         @(negedge clk);
      end
      chk("pre_rst_index", {29'b0, oi}, 32'd3);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_out_valid", {31'b0, ov}, 32'd0);
      chk("mid_rst_busy", {31'b0, bz}, 32'd0);
      chk("mid_rst_in_ready", {31'b0, ir}, 32'd0);
      chk("mid_rst_index", {29'b0, oi}, 32'd0);
      rst = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("mid_rst_in_ready_after", {31'b0, ir}, 32'd1);
      send_word(32'h0000_0000, 1'b1, -1, 0, 1'b0, 1'b0);
      send_word(32'h0000_0000, 1'b0, -1, 0, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         w = $urandom >> $urandom_range(0, 31);
         send_word(w, 1'(i % 2), -1, 0, 1'b1, 1'(i % 3 == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
